seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param_pkg.sv | 19 +
 rtl/seq_detector_param_if.sv | 28 ++
 rtl/seq_detector_param_sat_counter.sv | 22 ++
 rtl/seq_detector_param.sv | 101 ++++++++++
 tb/tb_seq_detector_param.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detector_param_pkg.sv
// Shared types and legal-range constants for the parametrised sequence detector.
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 32;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 16;

  function automatic bit width_ok(input int unsigned w, input int unsigned lo,
                                  input int unsigned hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Data, configuration and status signals of the sequence detector.
interface seq_detector_param_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) ();

  logic             in_valid;
  logic             din;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PAT_W-1:0] cfg_mask;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             match;
  logic             armed;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in_valid, din, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
    input  match, armed, match_cnt
  );

  modport slave (
    input  in_valid, din, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
    output match, armed, match_cnt
  );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime pattern, don't-care mask and overlap mode.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(4'b1010),
  parameter logic             DEF_OVERLAP = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  seq_detector_param_if.slave bus
);

  if (!width_ok(PAT_W, PAT_W_MIN, PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W out of range");
  end
  if (!width_ok(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W out of range");
  end

  localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  state_t             state;
  state_t             state_upd;
  logic [PAT_W-1:0]   hist;
  logic [PAT_W-1:0]   hist_next;
  logic [PAT_W-1:0]   pattern;
  logic [PAT_W-1:0]   mask;
  logic               overlap;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_next;
  logic [FILL_W-1:0]  fill_upd;
  logic               accept;
  logic               hit;
  logic               match_q;
  logic [CNT_W-1:0]   cnt;

  // Match is judged on the window as it will be after this bit shifts in.
  always_comb begin
    accept    = bus.in_valid & ~bus.cfg_load;
    hist_next = hist;
    fill_next = fill;
    if (accept) begin
      hist_next = {hist[PAT_W-2:0], bus.din};
      if (state != ARMED) begin
        fill_next = fill + FILL_W'(1);
      end
    end
    hit = accept && (fill_next == FILL_FULL) &&
          (((hist_next ^ pattern) & ~mask) == '0);
    if (hit && !overlap) begin
      fill_upd  = '0;
      state_upd = FILL;
    end else begin
      fill_upd  = fill_next;
      state_upd = (fill_next == FILL_FULL) ? ARMED : FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      hist    <= '0;
      fill    <= '0;
      pattern <= DEF_PATTERN;
      mask    <= '0;
      overlap <= DEF_OVERLAP;
      match_q <= 1'b0;
    end else if (bus.cfg_load) begin
      state   <= FILL;
      hist    <= '0;
      fill    <= '0;
      pattern <= bus.cfg_pattern;
      mask    <= bus.cfg_mask;
      overlap <= bus.cfg_overlap;
      match_q <= 1'b0;
    end else begin
      state   <= state_upd;
      hist    <= hist_next;
      fill    <= fill_upd;
      match_q <= hit;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (hit),
    .clr  (bus.cnt_clr),
    .cnt  (cnt)
  );

  assign bus.match     = match_q;
  assign bus.armed     = (state == ARMED);
  assign bus.match_cnt = cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// Vector-table and randomized checks of seq_detector_param against a window-queue model.
module tb_seq_detector_param;

  localparam int unsigned PAT_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(
    .PAT_W      (PAT_W),
    .CNT_W      (CNT_W),
    .DEF_PATTERN(4'b1010),
    .DEF_OVERLAP(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: the fresh bits since the last restart, oldest first.
  bit             win[$];
  bit [PAT_W-1:0] m_pat;
  bit [PAT_W-1:0] m_msk;
  bit             m_ov;
  int             m_cnt;
  bit             m_match;
  bit             m_armed;

  function automatic void model_reset();
    win.delete();
    m_pat   = 4'b1010;
    m_msk   = '0;
    m_ov    = 1'b1;
    m_cnt   = 0;
    m_match = 1'b0;
    m_armed = 1'b0;
  endfunction

  function automatic void model_step(input bit iv, input bit d, input bit load,
                                     input bit [PAT_W-1:0] pat, input bit [PAT_W-1:0] msk,
                                     input bit ov, input bit clr);
    bit ok;
    m_match = 1'b0;
    if (load) begin
      m_pat = pat;
      m_msk = msk;
      m_ov  = ov;
      win.delete();
    end else if (iv) begin
      win.push_back(d);
      if (win.size() > PAT_W) void'(win.pop_front());
      if (win.size() == PAT_W) begin
        ok = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
          if (!m_msk[PAT_W-1-i] && (win[i] != m_pat[PAT_W-1-i])) ok = 1'b0;
        end
        if (ok) begin
          m_match = 1'b1;
          if (!m_ov) win.delete();
        end
      end
    end
    m_armed = (win.size() == PAT_W);
    if (clr) m_cnt = 0;
    else if (m_match && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit iv, input bit d, input bit load,
                       input bit [PAT_W-1:0] pat, input bit [PAT_W-1:0] msk,
                       input bit ov, input bit clr, input bit chk);
    bus.in_valid    = iv;
    bus.din         = d;
    bus.cfg_load    = load;
    bus.cfg_pattern = pat;
    bus.cfg_mask    = msk;
    bus.cfg_overlap = ov;
    bus.cnt_clr     = clr;
    @(posedge clk);
    model_step(iv, d, load, pat, msk, ov, clr);
    #1;
    if (chk) begin
      check("model_match", int'(bus.match), int'(m_match));
      check("model_armed", int'(bus.armed), int'(m_armed));
      check("model_cnt",   int'(bus.match_cnt), m_cnt);
    end
  endtask

  task automatic bit_in(input bit d, input bit chk);
    cycle(1'b1, d, 1'b0, '0, '0, 1'b0, 1'b0, chk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #10 rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit             iv, d, load;
    bit [PAT_W-1:0] pat, msk;
    bit             ov, clr;
    bit             em, ea;
    int             ec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit iv, input bit d, input bit load,
                              input bit [PAT_W-1:0] pat, input bit [PAT_W-1:0] msk,
                              input bit ov, input bit clr,
                              input bit em, input bit ea, input int ec);
    vec_t v;
    v.iv = iv; v.d = d; v.load = load; v.pat = pat; v.msk = msk;
    v.ov = ov; v.clr = clr; v.em = em; v.ea = ea; v.ec = ec;
    tbl.push_back(v);
  endfunction

  function automatic void add_bit(input bit d, input bit em, input bit ea, input int ec);
    add(1'b1, d, 1'b0, '0, '0, 1'b0, 1'b0, em, ea, ec);
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.din = 1'b0; bus.cfg_load = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_mask = '0; bus.cfg_overlap = 1'b0; bus.cnt_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_match", int'(bus.match), 0);
    check("reset_armed", int'(bus.armed), 0);
    check("reset_cnt",   int'(bus.match_cnt), 0);
    #20 rst_n = 1'b1;
    @(negedge clk);

    // Overlap: 1011 in stream 1,0,1,1,0,1,1
    add(1'b0, 1'b0, 1'b1, 4'b1011, 4'b0000, 1'b1, 1'b0, 0, 0, 0);
    add_bit(1, 0, 0, 0); add_bit(0, 0, 0, 0); add_bit(1, 0, 0, 0);
    add_bit(1, 1, 1, 1); add_bit(0, 0, 1, 1); add_bit(1, 0, 1, 1);
    add_bit(1, 1, 1, 2);
    // Non-overlap, counter cleared alongside the load
    add(1'b0, 1'b0, 1'b1, 4'b1011, 4'b0000, 1'b0, 1'b1, 0, 0, 0);
    add_bit(1, 0, 0, 0); add_bit(0, 0, 0, 0); add_bit(1, 0, 0, 0);
    add_bit(1, 1, 0, 1); add_bit(0, 0, 0, 1); add_bit(1, 0, 0, 1);
    add_bit(1, 0, 0, 1); add_bit(0, 0, 1, 1);
    // Masking
    add(1'b0, 1'b0, 1'b1, 4'b1001, 4'b0110, 1'b1, 1'b1, 0, 0, 0);
    add_bit(1, 0, 0, 0); add_bit(1, 0, 0, 0); add_bit(1, 0, 0, 0);
    add_bit(1, 1, 1, 1);
    add(1'b0, 1'b0, 1'b1, 4'b1001, 4'b0110, 1'b1, 1'b0, 0, 0, 1);
    add_bit(0, 0, 0, 1); add_bit(1, 0, 0, 1); add_bit(1, 0, 0, 1);
    add_bit(1, 0, 1, 1);
    // Gapped valid, then cfg_load colliding with a valid bit
    add(1'b0, 1'b0, 1'b1, 4'b1011, 4'b0000, 1'b1, 1'b1, 0, 0, 0);
    add_bit(1, 0, 0, 0); add_bit(0, 0, 0, 0);
    add(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 0, 0, 0);
    add(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 0, 0, 0);
    add(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 0, 0, 0);
    add_bit(1, 0, 0, 0); add_bit(1, 1, 1, 1);
    add(1'b1, 1'b1, 1'b1, 4'b1011, 4'b0000, 1'b1, 1'b0, 0, 0, 1);
    add_bit(0, 0, 0, 1); add_bit(1, 0, 0, 1); add_bit(1, 0, 0, 1);
    add_bit(1, 0, 1, 1);

    foreach (tbl[i]) begin
      cycle(tbl[i].iv, tbl[i].d, tbl[i].load, tbl[i].pat, tbl[i].msk,
            tbl[i].ov, tbl[i].clr, 1'b0);
      check($sformatf("vec%0d_match", i), int'(bus.match), int'(tbl[i].em));
      check($sformatf("vec%0d_armed", i), int'(bus.armed), int'(tbl[i].ea));
      check($sformatf("vec%0d_cnt", i),   int'(bus.match_cnt), tbl[i].ec);
    end

    // Saturation on default pattern, then clear coinciding with a match
    do_reset();
    for (int i = 0; i < 600; i++) bit_in(((i % 2) == 0), 1'b1);
    check("sat_cnt", int'(bus.match_cnt), CNT_MAX);
    bit_in(1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    check("clr_vs_match_pulse", int'(bus.match), 1);
    check("clr_vs_match_cnt",   int'(bus.match_cnt), 0);

    // Asynchronous reset mid-stream with a non-default pattern and fill=3
    cycle(1'b0, 1'b0, 1'b1, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b1);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b1);
    bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_match", int'(bus.match), 0);
    check("async_rst_armed", int'(bus.armed), 0);
    check("async_rst_cnt",   int'(bus.match_cnt), 0);
    model_reset();
    #10 rst_n = 1'b1;
    @(negedge clk);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    check("post_rst_default_match", int'(bus.match), 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit             iv, d, ld, ov, clr;
      bit [PAT_W-1:0] pat, msk;
      iv  = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      ld  = ($urandom_range(0, 49) == 0);
      pat = PAT_W'($urandom);
      msk = PAT_W'($urandom) & PAT_W'($urandom) & PAT_W'($urandom);
      ov  = 1'($urandom);
      clr = ($urandom_range(0, 99) == 0);
      cycle(iv, d, ld, pat, msk, ov, clr, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
